// File: rtl/uart_tx_ctrl.sv
// UART transmit sequencer: pops one byte per frame from the TX FIFO and
// serialises it as start bit, D_W data bits LSB first, then one stop bit.
module uart_tx_ctrl #(
  parameter int D_W    = 8,
  parameter int B_TICK = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_tick,
  input  logic           tx_en,
  input  logic           fifo_empty,
  input  logic [D_W-1:0] fifo_data,
  output logic           fifo_rd_en,
  output logic           tx,
  output logic           tx_busy,
  output logic           tx_done_tick
);

  // state | meaning
  // IDLE  | line high, waiting for tx_en with a non-empty FIFO
  // FETCH | one-cycle FIFO pop strobe
  // LOAD  | registered FIFO data captured into the shift register
  // START | start bit (line low) for B_TICK ticks
  // DATA  | D_W data bits, LSB first, B_TICK ticks each
  // STOP  | stop bit (line high); done pulse on its last tick
  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  localparam int TW = $clog2(B_TICK);
  localparam int BW = $clog2(D_W) + 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(B_TICK - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(D_W - 1);

  state_t         state;
  logic [TW-1:0]  tick_cnt;
  logic [BW-1:0]  bit_cnt;
  logic [D_W-1:0] shreg;
  logic [D_W-1:0] shreg_nx;
  logic           bit_end;

  assign shreg_nx = shreg >> 1;
  assign bit_end  = s_tick && (tick_cnt == TICK_LAST);

  // Outputs are registered alongside the state so each one reflects the
  // state the FSM is in during that cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      tick_cnt     <= '0;
      bit_cnt      <= '0;
      shreg        <= '0;
      tx           <= 1'b1;
      fifo_rd_en   <= 1'b0;
      tx_busy      <= 1'b0;
      tx_done_tick <= 1'b0;
    end else begin
      fifo_rd_en   <= 1'b0;
      tx_done_tick <= 1'b0;
      case (state)
        IDLE: begin
          tx <= 1'b1;
          if (tx_en && !fifo_empty) begin
            state      <= FETCH;
            fifo_rd_en <= 1'b1;
            tx_busy    <= 1'b1;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shreg    <= fifo_data;
          tick_cnt <= '0;
          tx       <= 1'b0;
          state    <= START;
        end
        START: begin
          if (bit_end) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            tx       <= shreg[0];
            state    <= DATA;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        DATA: begin
          if (bit_end) begin
            tick_cnt <= '0;
            shreg    <= shreg_nx;
            bit_cnt  <= bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              tx <= shreg_nx[0];
            end
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        STOP: begin
          if (bit_end) begin
            tick_cnt     <= '0;
            tx_done_tick <= 1'b1;
            tx_busy      <= 1'b0;
            state        <= IDLE;
          end else if (s_tick) begin
            tick_cnt <= tick_cnt + 1'b1;
          end
        end
        default: begin
          tx      <= 1'b1;
          tx_busy <= 1'b0;
          state   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a queue-based FIFO model feeds the DUT and
// every line cycle is compared against the frame expected from the tick count.
module tb_uart_tx_ctrl;

  localparam int D_W    = 8;
  localparam int B_TICK = 16;
  localparam int FR_TICKS = (D_W + 2) * B_TICK;
  localparam int NONE = 99;

  logic           clk = 1'b0;
  logic           rst;
  logic           s_tick;
  logic           tx_en;
  logic           fifo_empty;
  logic [D_W-1:0] fifo_data;
  logic           fifo_rd_en;
  logic           tx;
  logic           tx_busy;
  logic           tx_done_tick;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc_n  = 0;
  int pops   = 0;
  int empty_pops = 0;
  int tick_mode  = 0;
  int frame_cyc  = 0;
  int dur [10];
  logic [D_W-1:0] fifo_q [$];

  uart_tx_ctrl #(.D_W(D_W), .B_TICK(B_TICK)) dut (
    .clk          (clk),
    .rst          (rst),
    .s_tick       (s_tick),
    .tx_en        (tx_en),
    .fifo_empty   (fifo_empty),
    .fifo_data    (fifo_data),
    .fifo_rd_en   (fifo_rd_en),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc_n);
    end
  endtask

  // Line level expected in a frame once k ticks have elapsed since the start bit began.
  function automatic logic exp_line(input logic [D_W-1:0] b, input int k);
    int bi;
    bi = k / B_TICK;
    if (bi == 0) return 1'b0;
    if (bi <= D_W) return b[bi-1];
    return 1'b1;
  endfunction

  task automatic push(input logic [D_W-1:0] b);
    fifo_q.push_back(b);
    fifo_empty = 1'b0;
  endtask

  // Advance one cycle: model the registered FIFO read, then drive this cycle's s_tick.
  task automatic cyc();
    logic pop;
    pop = fifo_rd_en;
    @(posedge clk);
    #1;
    cyc_n++;
    if (pop) begin
      pops++;
      if (fifo_q.size() > 0) fifo_data = fifo_q.pop_front();
      else empty_pops++;
    end
    fifo_empty = (fifo_q.size() == 0);
    case (tick_mode)
      0:       s_tick = 1'b1;
      1:       s_tick = (cyc_n % 4 == 3);
      default: s_tick = ($urandom_range(0, 2) == 0);
    endcase
  endtask

  // Called in the cycle where the idle DUT sees tx_en=1 and a non-empty FIFO.
  task automatic run_frame(input int abort_bit, input int drop_bit);
    logic [D_W-1:0] exp_b;
    int k, bi, start_c;
    exp_b = (fifo_q.size() > 0) ? fifo_q[0] : '0;
    foreach (dur[i]) dur[i] = 0;
    cyc();
    chk("fetch_rd_en", fifo_rd_en, 1);
    chk("fetch_busy", tx_busy, 1);
    chk("fetch_tx", tx, 1);
    cyc();
    chk("load_rd_en", fifo_rd_en, 0);
    chk("load_tx", tx, 1);
    cyc();
    k = 0;
    start_c = cyc_n;
    while (k < FR_TICKS) begin
      bi = k / B_TICK;
      chk("tx_bit", tx, exp_line(exp_b, k));
      chk("busy_frame", tx_busy, 1);
      chk("no_done_mid", tx_done_tick, 0);
      chk("no_pop_mid", fifo_rd_en, 0);
      dur[bi]++;
      if (bi == drop_bit + 1) tx_en = 1'b0;
      if (bi == abort_bit + 1 && (k % B_TICK) == 5) begin
        rst = 1'b1;
        #1;
        chk("rst_tx", tx, 1);
        chk("rst_busy", tx_busy, 0);
        chk("rst_rd_en", fifo_rd_en, 0);
        cyc();
        cyc();
        chk("rst_hold_tx", tx, 1);
        rst = 1'b0;
        return;
      end
      if (s_tick) k++;
      if (cyc_n - start_c > 5000) begin
        chk("frame_timeout", 0, 1);
        return;
      end
      cyc();
    end
    chk("done_tick", tx_done_tick, 1);
    chk("done_tx", tx, 1);
    chk("done_busy", tx_busy, 0);
    frame_cyc = cyc_n - start_c;
  endtask

  initial begin
    rst = 1'b1;
    tx_en = 1'b0;
    s_tick = 1'b0;
    fifo_empty = 1'b1;
    fifo_data = '0;
    repeat (3) cyc();
    chk("rst_state_tx", tx, 1);
    chk("rst_state_rd_en", fifo_rd_en, 0);
    chk("rst_state_busy", tx_busy, 0);
    chk("rst_state_done", tx_done_tick, 0);
    rst = 1'b0;
    cyc();

    // Empty FIFO with tx_en high: nothing happens.
    tx_en = 1'b1;
    repeat (100) begin
      cyc();
      chk("empty_rd_en", fifo_rd_en, 0);
      chk("empty_tx", tx, 1);
      chk("empty_busy", tx_busy, 0);
    end
    chk("empty_pops", pops, 0);

    // Single 0xA5 frame, s_tick constantly high.
    tick_mode = 0;
    push(8'hA5);
    run_frame(NONE, NONE);
    chk("a5_len", frame_cyc, 160);
    tx_en = 1'b0;
    cyc();
    chk("a5_done_once", tx_done_tick, 0);
    chk("a5_pops", pops, 1);

    // Back-to-back 0x01 then 0xFF.
    push(8'h01);
    push(8'hFF);
    tx_en = 1'b1;
    run_frame(NONE, NONE);
    run_frame(NONE, NONE);
    tx_en = 1'b0;
    repeat (5) cyc();
    chk("b2b_pops", pops, 3);
    chk("b2b_idle_busy", tx_busy, 0);

    // s_tick every 4th cycle, byte 0x3C.
    tick_mode = 1;
    push(8'h3C);
    tx_en = 1'b1;
    run_frame(NONE, NONE);
    tx_en = 1'b0;
    for (int i = 1; i < 10; i++) chk("div4_bit_len", dur[i], 64);
    chk("div4_start_len", (dur[0] >= 61 && dur[0] <= 64), 1);
    chk("div4_frame_len", (frame_cyc >= 637 && frame_cyc <= 640), 1);
    repeat (3) cyc();

    // tx_en dropped during data bit 3 with the FIFO still holding a byte.
    tick_mode = 0;
    push(8'h96);
    push(8'h5A);
    tx_en = 1'b1;
    run_frame(NONE, 3);
    repeat (30) begin
      cyc();
      chk("drop_no_rd_en", fifo_rd_en, 0);
      chk("drop_busy", tx_busy, 0);
    end
    chk("drop_pops", pops, 5);
    chk("drop_left", fifo_q.size(), 1);

    // Reset during data bit 5; the popped byte is lost, the next one goes out whole.
    push(8'hC3);
    tx_en = 1'b1;
    run_frame(5, NONE);
    chk("abort_pops", pops, 6);
    run_frame(NONE, NONE);
    chk("after_rst_pops", pops, 7);
    tx_en = 1'b0;
    repeat (3) cyc();

    // Random bytes, random tick spacing, random gaps.
    tick_mode = 2;
    for (int it = 0; it < 6; it++) begin
      int nb;
      nb = $urandom_range(1, 2);
      for (int j = 0; j < nb; j++) push(D_W'($urandom));
      tx_en = 1'b1;
      for (int j = 0; j < nb; j++) run_frame(NONE, NONE);
      tx_en = 1'b0;
      repeat ($urandom_range(1, 6)) cyc();
      chk("rand_idle_busy", tx_busy, 0);
      chk("rand_idle_tx", tx, 1);
    end
    chk("fifo_drained", fifo_q.size(), 0);
    chk("never_pop_empty", empty_pops, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
